// File: rtl/abs_pipe.sv
// Two-stage elastic absolute-value pipeline: S1 captures the raw signed beat,
// S2 holds the per-channel magnitude with sign and most-negative flags.
module abs_pipe #(
  parameter int WORD_WIDTH = 16,
  parameter int CHANNELS   = 1,
  parameter int SATURATE   = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*WORD_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS*WORD_WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]            out_sign,
  output logic [CHANNELS-1:0]            out_ovf
);

  localparam int DW = CHANNELS * WORD_WIDTH;

  logic          s1_valid;
  logic [DW-1:0] s1_data;
  logic          s2_valid;
  logic [DW-1:0] s2_data;
  logic [CHANNELS-1:0] s2_sign;
  logic [CHANNELS-1:0] s2_ovf;

  logic          s1_load;
  logic          s2_load;
  logic [DW-1:0] abs_data;
  logic [CHANNELS-1:0] abs_sign;
  logic [CHANNELS-1:0] abs_ovf;

  // S2 refills whenever it is empty or its beat leaves this cycle; S1 refills
  // when it is empty or its beat moves into S2 on the same edge.
  assign s2_load  = s1_valid && (!s2_valid || out_ready);
  assign s1_load  = in_valid && (!s1_valid || s2_load);
  assign in_ready = !s1_valid || !s2_valid || out_ready;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [WORD_WIDTH-1:0] x;
    logic [WORD_WIDTH-1:0] neg_x;
    logic [WORD_WIDTH-1:0] mag;
    logic                  is_min;

    assign x      = s1_data[k*WORD_WIDTH +: WORD_WIDTH];
    assign neg_x  = '0 - x;
    assign is_min = x[WORD_WIDTH-1] & ~(|x[WORD_WIDTH-2:0]);

    // Negating the most-negative value wraps back onto itself, which is
    // exactly its true unsigned magnitude when saturation is off.
    always_comb begin
      mag = x;
      if (is_min && (SATURATE != 0)) begin
        mag = {1'b0, {(WORD_WIDTH-1){1'b1}}};
      end else if (x[WORD_WIDTH-1]) begin
        mag = neg_x;
      end
    end

    assign abs_data[k*WORD_WIDTH +: WORD_WIDTH] = mag;
    assign abs_sign[k] = x[WORD_WIDTH-1];
    assign abs_ovf[k]  = is_min;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_data  <= in_data;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Result registers only change on a load, so they stay put during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_sign  <= '0;
      s2_ovf   <= '0;
    end else begin
      if (s2_load) begin
        s2_valid <= 1'b1;
        s2_data  <= abs_data;
        s2_sign  <= abs_sign;
        s2_ovf   <= abs_ovf;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_sign  = s2_sign;
  assign out_ovf   = s2_ovf;

endmodule

// File: tb/tb_abs_pipe.sv
// Self-checking bench for abs_pipe: three instances (C=1 saturating, C=1 wrapping,
// C=4 saturating) share handshake inputs and are checked against a queue model.
module tb_abs_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] in_data;

  logic        in_ready_a, in_ready_b, in_ready_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic [15:0] out_data_a, out_data_b;
  logic [63:0] out_data_c;
  logic [0:0]  out_sign_a, out_ovf_a, out_sign_b, out_ovf_b;
  logic [3:0]  out_sign_c, out_ovf_c;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  abs_pipe #(.WORD_WIDTH(16), .CHANNELS(1), .SATURATE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data[15:0]), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_sign(out_sign_a), .out_ovf(out_ovf_a));

  abs_pipe #(.WORD_WIDTH(16), .CHANNELS(1), .SATURATE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data[15:0]), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_sign(out_sign_b), .out_ovf(out_ovf_b));

  abs_pipe #(.WORD_WIDTH(16), .CHANNELS(4), .SATURATE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_data(in_data), .out_valid(out_valid_c), .out_ready(out_ready),
    .out_data(out_data_c), .out_sign(out_sign_c), .out_ovf(out_ovf_c));

  // Model state: beats accepted but not yet consumed, with their acceptance edge.
  typedef struct {
    logic [63:0] d;
    int          acc;
  } item_t;

  typedef struct {
    logic [15:0] da;
    logic [15:0] db;
    logic        sa;
    logic        oa;
    logic        sb;
    logic        ob;
    logic [63:0] dc;
    logic [3:0]  sc;
    logic [3:0]  oc;
    int          dep;
  } out_t;

  item_t q[$];
  out_t  outlog[$];
  int    cyc = 0;
  int    last_dep = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  // Magnitude from plain integer arithmetic on the signed value.
  function automatic void absModel(input logic [15:0] x, input bit sat,
                                   output logic [15:0] m, output logic s, output logic o);
    int v;
    int mag;
    v   = int'($signed(x));
    mag = (v < 0) ? -v : v;
    s   = (v < 0);
    o   = (v == -32768);
    if (o && sat) mag = 32767;
    m = mag[15:0];
  endfunction

  // The head beat reaches the output one edge after acceptance, but not before
  // the previous beat has left the output register.
  function automatic bit expValid();
    int entry;
    if (q.size() == 0) return 1'b0;
    entry = (q[0].acc + 1 > last_dep) ? q[0].acc + 1 : last_dep;
    return entry <= cyc;
  endfunction

  always @(posedge clk) begin
    bit v;
    bit r;
    v = expValid();
    r = (q.size() < 2) || out_ready;
    cyc++;
    if (rst_n) begin
      if (v && out_ready) begin
        void'(q.pop_front());
        last_dep = cyc;
      end
      if (in_valid && r) q.push_back('{in_data, cyc});
    end
  end

  always @(negedge rst_n) begin
    q.delete();
    last_dep = 0;
  end

  always @(negedge clk) begin
    logic [15:0] m;
    logic        s;
    logic        o;
    logic [63:0] emc;
    logic [3:0]  esc;
    logic [3:0]  eoc;
    bit          v;
    bit          r;
    if (!rst_n) begin
      checkOutput("reset_valid", {out_valid_a, out_valid_b, out_valid_c}, 64'd0);
      checkOutput("reset_data_ab", {out_data_a, out_data_b}, 64'd0);
      checkOutput("reset_data_c", out_data_c, 64'd0);
      checkOutput("reset_flags", {out_sign_a, out_ovf_a, out_sign_b, out_ovf_b,
                                  out_sign_c, out_ovf_c}, 64'd0);
    end else begin
      v = expValid();
      r = (q.size() < 2) || out_ready;
      checkOutput("in_ready_a", in_ready_a, r);
      checkOutput("in_ready_b", in_ready_b, r);
      checkOutput("in_ready_c", in_ready_c, r);
      checkOutput("out_valid_a", out_valid_a, v);
      checkOutput("out_valid_b", out_valid_b, v);
      checkOutput("out_valid_c", out_valid_c, v);
      if (v) begin
        absModel(q[0].d[15:0], 1'b1, m, s, o);
        checkOutput("data_a", out_data_a, m);
        checkOutput("flags_a", {out_sign_a, out_ovf_a}, {s, o});
        absModel(q[0].d[15:0], 1'b0, m, s, o);
        checkOutput("data_b", out_data_b, m);
        checkOutput("flags_b", {out_sign_b, out_ovf_b}, {s, o});
        for (int k = 0; k < 4; k++) begin
          absModel(q[0].d[k*16 +: 16], 1'b1, m, s, o);
          emc[k*16 +: 16] = m;
          esc[k] = s;
          eoc[k] = o;
        end
        checkOutput("data_c", out_data_c, emc);
        checkOutput("sign_c", out_sign_c, esc);
        checkOutput("ovf_c", out_ovf_c, eoc);
      end
      if (out_valid_a && out_ready)
        outlog.push_back('{out_data_a, out_data_b, out_sign_a[0], out_ovf_a[0],
                           out_sign_b[0], out_ovf_b[0], out_data_c, out_sign_c,
                           out_ovf_c, cyc + 1});
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] e030_d[4] = '{16'h0F50, 16'h00B0, 16'h0001, 16'h7FFF};
    logic        e030_s[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] e033_d[10] = '{16'd5, 16'd4, 16'd3, 16'd2, 16'd1,
                                16'd0, 16'd1, 16'd2, 16'd3, 16'd4};
    logic        e033_s[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int first_acc;
    int sent;
    int budget;
    bit v;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 checkOutput("in_ready_after_reset", in_ready_a, 1'b1);

    $display("[TB] basic stream, full throughput");
    outlog.delete();
    applyStimulus(1'b1, {4{16'h0F50}}, 1'b1);
    applyStimulus(1'b1, {4{16'hFF50}}, 1'b1);
    first_acc = cyc;
    applyStimulus(1'b1, {4{16'hFFFF}}, 1'b1);
    applyStimulus(1'b1, {4{16'h7FFF}}, 1'b1);
    repeat (4) applyStimulus(1'b0, 64'd0, 1'b1);
    checkOutput("stream_count", outlog.size(), 64'd4);
    for (int i = 0; i < 4 && i < outlog.size(); i++) begin
      checkOutput($sformatf("stream_data[%0d]", i), outlog[i].da, e030_d[i]);
      checkOutput($sformatf("stream_flags[%0d]", i), {outlog[i].sa, outlog[i].oa}, {e030_s[i], 1'b0});
    end
    if (outlog.size() >= 4) begin
      checkOutput("stream_latency", outlog[0].dep, first_acc + 2);
      checkOutput("stream_no_bubble", outlog[3].dep, outlog[0].dep + 3);
    end

    $display("[TB] most-negative and multichannel");
    outlog.delete();
    applyStimulus(1'b1, {48'd0, 16'h8000}, 1'b1);
    applyStimulus(1'b1, {16'h8000, 16'h0000, 16'hAAAA, 16'h55A5}, 1'b1);
    repeat (4) applyStimulus(1'b0, 64'd0, 1'b1);
    checkOutput("minneg_count", outlog.size(), 64'd2);
    if (outlog.size() >= 2) begin
      checkOutput("minneg_sat", {outlog[0].da, outlog[0].sa, outlog[0].oa}, {16'h7FFF, 1'b1, 1'b1});
      checkOutput("minneg_wrap", {outlog[0].db, outlog[0].sb, outlog[0].ob}, {16'h8000, 1'b1, 1'b1});
      checkOutput("multi_data", outlog[1].dc, {16'h7FFF, 16'h0000, 16'h5556, 16'h55A5});
      checkOutput("multi_flags", {outlog[1].sc, outlog[1].oc}, {4'b1010, 4'b1000});
    end

    $display("[TB] random backpressure stream");
    outlog.delete();
    sent = 0;
    budget = 0;
    while (sent < 10 && budget < 500) begin
      v = ($urandom_range(0, 3) != 0);
      applyStimulus(v, {4{16'hFFFB + 16'(sent)}}, 1'($urandom_range(0, 1)));
      @(negedge clk);
      if (v && in_ready_a) sent++;
      budget++;
    end
    budget = 0;
    while (outlog.size() < 10 && budget < 500) begin
      applyStimulus(1'b0, 64'd0, 1'($urandom_range(0, 1)));
      budget++;
    end
    applyStimulus(1'b0, 64'd0, 1'b1);
    checkOutput("bp_count", outlog.size(), 64'd10);
    for (int i = 0; i < 10 && i < outlog.size(); i++)
      checkOutput($sformatf("bp_order[%0d]", i), {outlog[i].da, outlog[i].sa}, {e033_d[i], e033_s[i]});

    $display("[TB] reset with beats in flight");
    outlog.delete();
    applyStimulus(1'b1, {4{16'h1234}}, 1'b0);
    applyStimulus(1'b1, {4{16'h8001}}, 1'b0);
    applyStimulus(1'b0, 64'd0, 1'b0);
    checkOutput("inflight_full", {out_valid_a, in_ready_a}, 2'b10);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset_valid", out_valid_a, 1'b0);
    checkOutput("async_reset_data", {out_data_a, out_sign_a, out_ovf_a}, 64'd0);
    checkOutput("async_reset_data_c", out_data_c, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) applyStimulus(1'b0, 64'd0, 1'b1);
    checkOutput("no_stale_after_reset", outlog.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
